// File: rtl/logic_mux2_pkg.sv
// Shared constants and parity helper for the logic_mux2 registered selector.
// Parity helper is used only when LOGIC_MUX2_PARITY_EN is defined.
package logic_mux2_pkg;

   localparam int unsigned LOGIC_MUX2_MAX_WIDTH = 64;
   localparam int unsigned LOGIC_MUX2_DEF_WIDTH = 1;

   // Even parity over a zero-extended word; zero padding leaves the XOR unchanged.
   function automatic logic logic_mux2_parity(input logic [LOGIC_MUX2_MAX_WIDTH-1:0] i_val);
      return ^i_val;
   endfunction

endpackage

// File: rtl/logic_mux2_if.sv
// Data/select/result bundle for logic_mux2; y_par exists only with LOGIC_MUX2_PARITY_EN.
interface logic_mux2_if #(
   parameter int unsigned WIDTH = logic_mux2_pkg::LOGIC_MUX2_DEF_WIDTH
);

   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic [WIDTH-1:0] y;
   logic             y_vld;
`ifdef LOGIC_MUX2_PARITY_EN
   logic             y_par;
`endif

   modport master (
      output en, a, b, c,
`ifdef LOGIC_MUX2_PARITY_EN
      input  y_par,
`endif
      input  y, y_vld
   );

   modport slave (
      input  en, a, b, c,
`ifdef LOGIC_MUX2_PARITY_EN
      output y_par,
`endif
      output y, y_vld
   );

endinterface

// File: rtl/logic_mux2_sel.sv
// Purely combinational WIDTH-bit 2:1 selector: o_sel = i_c ? i_b : i_a.
module logic_mux2_sel
   import logic_mux2_pkg::*;
#(
   parameter int unsigned WIDTH = LOGIC_MUX2_DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c,
   output logic [WIDTH-1:0] o_sel
);

   always_comb begin
      o_sel = i_c ? i_b : i_a;
   end

endmodule

// File: rtl/logic_mux2.sv
// Registered 2:1 selector with a one-cycle valid flag.
// Optional registered even parity output y_par when LOGIC_MUX2_PARITY_EN is defined.
module logic_mux2
   import logic_mux2_pkg::*;
#(
   parameter int unsigned                          WIDTH     = LOGIC_MUX2_DEF_WIDTH,
   parameter logic [LOGIC_MUX2_MAX_WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   logic_mux2_if.slave bus
);

   localparam logic [WIDTH-1:0] RstY = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] w_sel;
   logic [WIDTH-1:0] r_y;
   logic             r_y_vld;

   logic_mux2_sel #(
      .WIDTH (WIDTH)
   ) u_sel (
      .i_a   (bus.a),
      .i_b   (bus.b),
      .i_c   (bus.c),
      .o_sel (w_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= RstY;
         r_y_vld <= 1'b0;
      end else begin
         r_y_vld <= bus.en;
         if (bus.en) begin
            r_y <= w_sel;
         end
      end
   end

   assign bus.y     = r_y;
   assign bus.y_vld = r_y_vld;

`ifdef LOGIC_MUX2_PARITY_EN
   localparam logic RstPar = logic_mux2_parity(LOGIC_MUX2_MAX_WIDTH'(RstY));

   logic r_y_par;

   // Parity is taken from sel, not from y, so it lands on the same edge as y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_par <= RstPar;
      end else if (bus.en) begin
         r_y_par <= logic_mux2_parity(LOGIC_MUX2_MAX_WIDTH'(w_sel));
      end
   end

   assign bus.y_par = r_y_par;
`endif

endmodule

// File: tb/tb_logic_mux2.sv
// Bench for logic_mux2: a WIDTH=1 and a WIDTH=8 instance driven from one vector table.
// Parity checks are compiled in only with LOGIC_MUX2_PARITY_EN.
module tb_logic_mux2;

   typedef struct packed {
      logic       en;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       e1;
      logic [7:0] e8;
      logic       ev;
      logic       ep;
   } vec_t;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_errors;

   vec_t vecs[$];
   vec_t sb[$];

   logic_mux2_if #(.WIDTH(1)) bus1 ();
   logic_mux2_if #(.WIDTH(8)) bus8 ();

   logic_mux2 #(
      .WIDTH     (1),
      .RESET_VAL (64'h0)
   ) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Upper RESET_VAL bits must be dropped: y resets to 8'hA5.
   logic_mux2 #(
      .WIDTH     (8),
      .RESET_VAL (64'h0123_4567_89AB_CDA5)
   ) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t e);
      check({tag, ".y1"}, 64'(bus1.y), 64'(e.e1));
      check({tag, ".vld1"}, 64'(bus1.y_vld), 64'(e.ev));
      check({tag, ".y8"}, 64'(bus8.y), 64'(e.e8));
      check({tag, ".vld8"}, 64'(bus8.y_vld), 64'(e.ev));
`ifdef LOGIC_MUX2_PARITY_EN
      check({tag, ".par8"}, 64'(bus8.y_par), 64'(e.ep));
`endif
   endtask

   task automatic drive(input vec_t v);
      bus1.en = v.en;
      bus1.a  = v.a[0];
      bus1.b  = v.b[0];
      bus1.c  = v.c;
      bus8.en = v.en;
      bus8.a  = v.a;
      bus8.b  = v.b;
      bus8.c  = v.c;
   endtask

   task automatic pop_and_check(input string tag);
      vec_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s.scoreboard: got empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         check_outputs(tag, e);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      sb.push_back(v);
      @(posedge clk);
      #1;
      pop_and_check(tag);
   endtask

   vec_t rst_exp;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_exp  = vec_t'{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         vecs.push_back(vec_t'{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0});
         vecs.push_back(vec_t'{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
      end
      vecs.push_back(vec_t'{1'b1, 8'hA4, 8'h3D, 1'b0, 1'b0, 8'hA4, 1'b1, 1'b1});
      vecs.push_back(vec_t'{1'b1, 8'hA4, 8'h3D, 1'b1, 1'b1, 8'h3D, 1'b1, 1'b1});
      vecs.push_back(vec_t'{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h81, 8'h00, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h66, 8'h66, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h66, 8'h66, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h07, 8'hF0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1});
      vecs.push_back(vec_t'{1'b1, 8'hF0, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0});

      // Power-on reset with the clock running: outputs must sit at reset values.
      rst_n = 1'b0;
      drive(vec_t'{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por", rst_exp);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous assertion between edges, checked before the next edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_outputs("async_rst", rst_exp);
      @(posedge clk);
      #1;
      check_outputs("rst_hold", rst_exp);
      @(negedge clk);
      rst_n = 1'b1;
      apply(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0}, "post_rst");

      // Mid-stream reset: the capture pending at the next edge is discarded.
      @(negedge clk);
      drive(vec_t'{1'b1, 8'h00, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      rst_n = 1'b0;
      #1;
      check_outputs("mid_rst", rst_exp);
      @(posedge clk);
      #1;
      check_outputs("mid_discard", rst_exp);
      #1;
      rst_n = 1'b1;
      sb.push_back(vec_t'{1'b1, 8'h00, 8'hFE, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1});
      @(posedge clk);
      #1;
      pop_and_check("mid_first");

      apply(vec_t'{1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1}, "final_hold");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/logic_mux2.md
Name: logic_mux2

Overview:
- Registered 2:1 selector: output y takes input a when select c=0 and input b when select c=1.
- Captured on the rising clock edge, with one cycle of latency.
- Used as a glue-level data steering element between datapath stages. It carries a valid flag so downstream logic knows when y holds a freshly selected value.

Parameters:
- WIDTH, 1, data width of a, b and y in bits (legal range 1..64).
- RESET_VAL, 0, value loaded into y on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when 1, the selected input is registered this cycle
- a  input  WIDTH  data input chosen when c=0
- b  input  WIDTH  data input chosen when c=1
- c  input  1  select
- y  output  WIDTH  registered selected data
- y_vld  output  1  1 for exactly the cycle after a capture (en=1), else 0

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately (asynchronously) forces y=RESET_VAL and y_vld=0.
  - Outputs hold these values while rst_n=0.
  - Reset is released synchronously to clk by the surrounding system.
  - The first capture can occur on the first rising edge with rst_n=1.
- Selection, combinational inside the block: sel = c ? b : a, bitwise over WIDTH.
- Capture at each rising edge of clk with rst_n=1:
  - en=1: y <= sel and y_vld <= 1.
  - en=0: y holds its previous value and y_vld <= 0.
- Latency: exactly 1 cycle from inputs sampled with en=1 to y/y_vld.
- Back-to-back captures are allowed every cycle; y_vld then stays 1 continuously.
- a=b: y equals that value regardless of c.
- c unknown (X) with a≠b: y is not specified. Benches must drive c to a known value whenever en=1.
- Reset mid-stream: a capture pending in the same cycle is discarded. y returns to RESET_VAL and y_vld to 0 without waiting for a clock edge.
- No internal state other than the y and y_vld registers (plus the optional parity register).

Optional Feature:
- Macro LOGIC_MUX2_PARITY_EN.
- When defined:
  - Adds output port y_par (1 bit), the registered even parity of y: XOR-reduction of sel, captured on the same edge and with the same en as y.
  - Reset value is the XOR-reduction of RESET_VAL.
  - y_par holds its value when en=0.
- When undefined: port y_par and its register do not exist; all other behaviour is identical.

Decomposition:
- Package logic_mux2_pkg holds:
  - constant LOGIC_MUX2_MAX_WIDTH = 64;
  - default width constant LOGIC_MUX2_DEF_WIDTH = 1;
  - a function computing XOR-reduction parity for the optional feature.
- One natural sub-module, logic_mux2_sel: purely combinational WIDTH-bit 2:1 selector (a, b, c -> sel).
- The top level wraps logic_mux2_sel with the y/y_vld (and optional y_par) registers.

Test Plan:
- Reset: rst_n=0 asynchronously between clock edges -> y=RESET_VAL (0) and y_vld=0 immediately, before the next edge.
- Select a: WIDTH=1, en=1, a=1, b=1, c=0 -> after 1 edge y=1, y_vld=1. Then a=0, b=0, c=1 -> after the next edge y=0, y_vld=1. Alternate these two vectors 10 times, 1 cycle each; y tracks with 1-cycle lag.
- Select distinguishing: a=0, b=1, c=0 -> y=0; then c=1 -> y=1; then a=1, b=0, c=1 -> y=0. WIDTH=8 variant: a=8'hA5, b=8'h3C, c=1 -> y=8'h3C.
- Enable hold: capture y=1, then en=0 with a=0, b=0 for 3 cycles -> y stays 1 and y_vld=0 for those 3 cycles.
- Reset mid-stream: en=1 with c=1, b=1, and rst_n pulsed low for half a cycle -> y=0 and y_vld=0 during and after the pulse. The first edge after release captures normally.
- Parity (LOGIC_MUX2_PARITY_EN, WIDTH=8): a=8'h07, c=0, en=1 -> y_par=1; then b=8'h03, c=1 -> y_par=0.
